reg_file_wb: RTL

- MIPS general-purpose register file and the consumer of the writeback triple RegDest / Data2Reg / RegWrite.
- Holds 32 x 32-bit registers with two combinational read ports for decode and one synchronous write port from writeback.
- Provides write-through bypass and a per-register pending-write scoreboard that lets decode detect RAW hazards against in-flight instructions.

---
 rtl/mips_pkg.sv | 19 +
 rtl/wb_scoreboard.sv | 64 ++++++
 rtl/reg_file_wb.sv | 67 ++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types used by decode, writeback and the register file.
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NREGS    = 1 << ADDR_W;
    localparam int ZERO_REG = 0;
    localparam int LINK_REG = 31;

    typedef logic [ADDR_W-1:0] regidx_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W:0]   count_t;

    // True when the index names a real, writable register.
    function automatic logic is_writable(input regidx_t idx);
        return idx != regidx_t'(ZERO_REG);
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on retire,
// with a registered count of how many registers are outstanding.
module wb_scoreboard
    import mips_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    issue_en,
    input  regidx_t issue_dest,
    input  logic    retire_en,
    input  regidx_t retire_dest,
    input  regidx_t rs_addr,
    input  regidx_t rt_addr,
    output logic    rs_pending,
    output logic    rt_pending,
    output count_t  pend_count
);

    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_next;
    logic             set_new;
    logic             cleared;
    logic             issue_ok;
    logic             retire_ok;

    assign issue_ok  = issue_en  && is_writable(issue_dest);
    assign retire_ok = retire_en && is_writable(retire_dest);

    // Next pending vector; an issue beats a retire of the same register because
    // the issued instruction is a newer writer that is still outstanding.
    always_comb begin
        pending_next = pending;
        set_new      = 1'b0;
        cleared      = 1'b0;
        if (retire_ok) begin
            pending_next[retire_dest] = 1'b0;
            cleared = pending[retire_dest] && !(issue_ok && issue_dest == retire_dest);
        end
        if (issue_ok) begin
            pending_next[issue_dest] = 1'b1;
            set_new = !pending[issue_dest];
        end
    end

    // Pending bits and their population count move together on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            pend_count <= '0;
        end else begin
            pending    <= pending_next;
            pend_count <= pend_count + count_t'(set_new) - count_t'(cleared);
        end
    end

    // A retire in this cycle is bypassed to the reader, so it no longer counts as a hazard.
    always_comb begin
        rs_pending = pending[rs_addr] && !(retire_en && retire_dest == rs_addr)
                     && is_writable(rs_addr);
        rt_pending = pending[rt_addr] && !(retire_en && retire_dest == rt_addr)
                     && is_writable(rt_addr);
    end

endmodule

// File: rtl/reg_file_wb.sv
// MIPS register file: 32x32 storage, two bypassed combinational read ports,
// one writeback port, and a pending-write scoreboard for RAW hazard detection.
module reg_file_wb
    import mips_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    RegWrite,
    input  regidx_t RegDest,
    input  word_t   Data2Reg,
    input  regidx_t RsAddr,
    input  regidx_t RtAddr,
    output word_t   RsData,
    output word_t   RtData,
    input  logic    IssueEn,
    input  regidx_t IssueDest,
    output logic    RsPending,
    output logic    RtPending,
    output count_t  PendCount
);

    word_t regs [NREGS];

    // Writeback port; register zero is never written so it stays at its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (RegWrite && is_writable(RegDest)) begin
            regs[RegDest] <= Data2Reg;
        end
    end

    // Read ports: zero register reads 0, a same-cycle writeback is forwarded, else storage.
    always_comb begin
        RsData = regs[RsAddr];
        RtData = regs[RtAddr];
        if (RegWrite && RegDest == RsAddr) begin
            RsData = Data2Reg;
        end
        if (RegWrite && RegDest == RtAddr) begin
            RtData = Data2Reg;
        end
        if (!is_writable(RsAddr)) begin
            RsData = '0;
        end
        if (!is_writable(RtAddr)) begin
            RtData = '0;
        end
    end

    wb_scoreboard u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_en    (IssueEn),
        .issue_dest  (IssueDest),
        .retire_en   (RegWrite),
        .retire_dest (RegDest),
        .rs_addr     (RsAddr),
        .rt_addr     (RtAddr),
        .rs_pending  (RsPending),
        .rt_pending  (RtPending),
        .pend_count  (PendCount)
    );

endmodule
